// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl
// Scan controller for a four-digit seven-segment display. Producers write
// digit values into a shadow bank; a commit copies the whole shadow bank into
// the active bank atomically at the end of a frame. The active bank is
// time-multiplexed onto the shared cathode bus, one digit per slot. Each slot
// opens with a blank gap to suppress ghosting between digits.
//
// Parameters:
//   PRESCALE     sysclock cycles per digit slot, blank gap included (2..65536)
//   BLANK        blank cycles at the start of each slot (0..PRESCALE-1)
// Ports:
//   sysclock       in   clock, rising edge
//   reset_n        in   synchronous active-low reset
//   wr_en          in   write strobe into the shadow bank
//   wr_addr[1:0]   in   digit index being written
//   wr_data[3:0]   in   digit value being written
//   wr_dp          in   decimal point for the written digit, 1 = lit
//   commit         in   copy shadow to active at the next frame end
//   digit_mask[3:0] in  per-digit enable, 1 = may light
//   lz_suppress    in   blank leading zeros
//   anode[3:0]     out  active-low one-hot anode drive (registered)
//   digit[3:0]     out  value of the digit in the current slot (registered)
//   dp_n           out  active-low decimal point (registered)
//   frame_done     out  one-cycle pulse at the end of digit 3's slot
//   commit_pending out  a commit is latched but not yet applied
module seg_scan_ctrl #(
  parameter int PRESCALE = 50000,
  parameter int BLANK    = 1000
) (
  input  logic       sysclock,
  input  logic       reset_n,
  input  logic       wr_en,
  input  logic [1:0] wr_addr,
  input  logic [3:0] wr_data,
  input  logic       wr_dp,
  input  logic       commit,
  input  logic [3:0] digit_mask,
  input  logic       lz_suppress,
  output logic [3:0] anode,
  output logic [3:0] digit,
  output logic       dp_n,
  output logic       frame_done,
  output logic       commit_pending
);

  localparam logic [15:0] SLOT_LAST = 16'(PRESCALE - 1);
  localparam logic [15:0] BLANK_C   = 16'(BLANK);

  // A digit is visible when enabled and, under leading-zero suppression, when
  // some enabled digit at or above it is nonzero. Digit 0 always survives so
  // an all-zero display still shows a single 0.
  function automatic logic [3:0] visible(input logic [3:0]      mask,
                                         input logic            lz,
                                         input logic [3:0][3:0] vals);
    logic [3:0] vis;
    logic       zero_above;
    zero_above = 1'b1;
    for (int i = 3; i >= 0; i--) begin
      if (mask[i] && (vals[i] != 4'd0)) zero_above = 1'b0;
      vis[i] = mask[i] && !(lz && (i != 0) && zero_above);
    end
    return vis;
  endfunction

  logic [15:0]      cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [3:0][3:0]  sh_val_q, sh_val_d;
  logic [3:0]       sh_dp_q, sh_dp_d;
  logic [3:0][3:0]  act_val_q, act_val_d;
  logic [3:0]       act_dp_q, act_dp_d;
  logic             pend_q, pend_d;
  logic [3:0]       anode_q, anode_d;
  logic [3:0]       digit_q, digit_d;
  logic             dp_n_q, dp_n_d;
  logic             frame_done_q, frame_done_d;

  logic             slot_end;
  logic             frame_end;
  logic             lit;
  logic [3:0]       vis;

  always_comb begin
    cnt_d     = cnt_q + 16'd1;
    idx_d     = idx_q;
    sh_val_d  = sh_val_q;
    sh_dp_d   = sh_dp_q;
    act_val_d = act_val_q;
    act_dp_d  = act_dp_q;

    slot_end  = (cnt_q == SLOT_LAST);
    frame_end = slot_end && (idx_q == 2'd3);

    if (slot_end) begin
      cnt_d = 16'd0;
      idx_d = idx_q + 2'd1;
    end

    // The active bank copies the shadow as it stood before this edge, so a
    // write landing in the frame-end cycle stays in shadow only.
    if (frame_end && pend_q) begin
      act_val_d = sh_val_q;
      act_dp_d  = sh_dp_q;
    end

    if (wr_en) begin
      sh_val_d[wr_addr] = wr_data;
      sh_dp_d[wr_addr]  = wr_dp;
    end

    // A commit arriving in the frame-end cycle re-arms pending rather than
    // being absorbed by the copy happening on that same edge.
    pend_d = commit || (pend_q && !frame_end);

    vis          = visible(digit_mask, lz_suppress, act_val_q);
    lit          = (cnt_q >= BLANK_C) && vis[idx_q];
    anode_d      = lit ? ~(4'b0001 << idx_q) : 4'hF;
    digit_d      = act_val_q[idx_q];
    dp_n_d       = lit ? ~act_dp_q[idx_q] : 1'b1;
    frame_done_d = frame_end;
  end

  always_ff @(posedge sysclock) begin
    if (!reset_n) begin
      cnt_q        <= 16'd0;
      idx_q        <= 2'd0;
      sh_val_q     <= '0;
      sh_dp_q      <= '0;
      act_val_q    <= '0;
      act_dp_q     <= '0;
      pend_q       <= 1'b0;
      anode_q      <= 4'hF;
      digit_q      <= 4'd0;
      dp_n_q       <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      sh_val_q     <= sh_val_d;
      sh_dp_q      <= sh_dp_d;
      act_val_q    <= act_val_d;
      act_dp_q     <= act_dp_d;
      pend_q       <= pend_d;
      anode_q      <= anode_d;
      digit_q      <= digit_d;
      dp_n_q       <= dp_n_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign anode          = anode_q;
  assign digit          = digit_q;
  assign dp_n           = dp_n_q;
  assign frame_done     = frame_done_q;
  assign commit_pending = pend_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Testbench for seg_scan_ctrl: directed scenarios followed by random traffic,
// every cycle compared against a behavioural model driven by the elapsed
// cycle count since reset.
module tb_seg_scan_ctrl;

  localparam int P = 8;
  localparam int B = 2;
  localparam int FRAME = 4 * P;

  logic       sysclock = 1'b0;
  logic       reset_n = 1'b0;
  logic       wr_en = 1'b0;
  logic [1:0] wr_addr = 2'd0;
  logic [3:0] wr_data = 4'd0;
  logic       wr_dp = 1'b0;
  logic       commit = 1'b0;
  logic [3:0] digit_mask = 4'hF;
  logic       lz_suppress = 1'b0;
  logic [3:0] anode;
  logic [3:0] digit;
  logic       dp_n;
  logic       frame_done;
  logic       commit_pending;

  always #5 sysclock = ~sysclock;

  seg_scan_ctrl #(.PRESCALE(P), .BLANK(B)) dut (
    .sysclock(sysclock), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_dp(wr_dp), .commit(commit), .digit_mask(digit_mask),
    .lz_suppress(lz_suppress), .anode(anode), .digit(digit), .dp_n(dp_n),
    .frame_done(frame_done), .commit_pending(commit_pending)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Model state: cycles elapsed since reset plus the two banks and pending.
  int         m_t;
  logic [3:0] m_sh[4];
  logic [3:0] m_act[4];
  logic       m_shdp[4];
  logic       m_actdp[4];
  logic       m_pend;
  logic [3:0] e_anode;
  logic [3:0] e_digit;
  logic       e_dp_n;
  logic       e_fd;

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic is_visible(int i);
    if (!digit_mask[i]) return 1'b0;
    if (!lz_suppress || i == 0) return 1'b1;
    for (int j = i; j < 4; j++)
      if (digit_mask[j] && m_act[j] != 4'd0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_edge();
    int pos, idx, c;
    logic fe, lit;
    logic [3:0] one;
    one = 4'b0001;
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) begin
        m_sh[i] = 4'd0; m_act[i] = 4'd0; m_shdp[i] = 1'b0; m_actdp[i] = 1'b0;
      end
      m_pend = 1'b0; m_t = 0;
      e_anode = 4'hF; e_digit = 4'd0; e_dp_n = 1'b1; e_fd = 1'b0;
      return;
    end
    pos = m_t % FRAME;
    idx = pos / P;
    c   = pos % P;
    fe  = (pos == FRAME - 1);
    lit = (c >= B) && is_visible(idx);
    e_anode = lit ? (4'hF ^ (one << idx)) : 4'hF;
    e_digit = m_act[idx];
    e_dp_n  = lit ? !m_actdp[idx] : 1'b1;
    e_fd    = fe;
    if (fe && m_pend)
      for (int i = 0; i < 4; i++) begin
        m_act[i] = m_sh[i]; m_actdp[i] = m_shdp[i];
      end
    if (wr_en) begin
      m_sh[wr_addr] = wr_data; m_shdp[wr_addr] = wr_dp;
    end
    m_pend = commit || (m_pend && !fe);
    m_t++;
  endtask

  task automatic step();
    @(posedge sysclock);
    model_edge();
    #1;
    cyc++;
    check_eq("anode", 16'(anode), 16'(e_anode));
    check_eq("digit", 16'(digit), 16'(e_digit));
    check_eq("dp_n", 16'(dp_n), 16'(e_dp_n));
    check_eq("frame_done", 16'(frame_done), 16'(e_fd));
    check_eq("commit_pending", 16'(commit_pending), 16'(m_pend));
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic write(input logic [1:0] a, input logic [3:0] d, input logic dp);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_dp = dp;
    step();
    wr_en = 1'b0;
  endtask

  task automatic pulse_commit();
    commit = 1'b1;
    step();
    commit = 1'b0;
  endtask

  initial begin
    // Reset then idle for a full frame.
    reset_n = 1'b0;
    run(2);
    reset_n = 1'b1;
    run(32);

    // Writes without commit stay invisible; then commit.
    write(2'd0, 4'd1, 1'b0);
    write(2'd1, 4'd2, 1'b0);
    write(2'd2, 4'd3, 1'b0);
    write(2'd3, 4'd4, 1'b0);
    run(10);
    pulse_commit();
    run(70);

    // Leading-zero suppression with active = {0,0,5,0}.
    write(2'd0, 4'd0, 1'b0);
    write(2'd1, 4'd5, 1'b0);
    write(2'd2, 4'd0, 1'b0);
    write(2'd3, 4'd0, 1'b0);
    pulse_commit();
    lz_suppress = 1'b1;
    run(72);
    lz_suppress = 1'b0;

    // Commit and write landing exactly on the frame-end cycle.
    for (int k = 0; k < 2 * FRAME && (m_t % FRAME) != FRAME - 1; k++) step();
    commit = 1'b1; wr_en = 1'b1; wr_addr = 2'd0; wr_data = 4'd9; wr_dp = 1'b0;
    step();
    commit = 1'b0; wr_en = 1'b0;
    run(80);

    // Masked digits and a decimal point on digit 2.
    digit_mask = 4'b0101;
    write(2'd2, 4'd7, 1'b1);
    pulse_commit();
    run(72);
    digit_mask = 4'hF;

    // Random traffic.
    for (int k = 0; k < 800; k++) begin
      wr_en   = 1'($urandom_range(0, 1));
      wr_addr = 2'($urandom);
      wr_data = 4'($urandom);
      wr_dp   = 1'($urandom);
      commit  = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 49) == 0) digit_mask = 4'($urandom);
      if ($urandom_range(0, 49) == 0) lz_suppress = 1'($urandom);
      reset_n = ($urandom_range(0, 299) != 0);
      step();
    end
    wr_en = 1'b0; commit = 1'b0; reset_n = 1'b1;
    digit_mask = 4'hF; lz_suppress = 1'b0;
    run(4);

    // Reset mid-slot while a commit is pending.
    write(2'd3, 4'd8, 1'b1);
    pulse_commit();
    for (int k = 0; k < P && (m_t % P) != 4; k++) step();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    run(40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
